// File: rtl/hft_egress_pkg.sv
// Shared types and constants for the quote egress path.
//
// Contents:
//   NUM_REGS        registers per one-sided quote message
//   egress_side_t   side tag carried on the stream (buy / sell)
//   egress_state_t  serializer FSM states
package hft_egress_pkg;

    localparam int NUM_REGS = 9;

    typedef enum logic {
        SIDE_BUY  = 1'b0,
        SIDE_SELL = 1'b1
    } egress_side_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND_BUY  = 2'd1,
        SEND_SELL = 2'd2
    } egress_state_t;

endpackage

// File: rtl/egress_pair_fifo.sv
// Synchronous FIFO holding whole buy/sell quote pairs.
//
// Besides the head entry it also exposes the entry behind the head, so the
// serializer can start the following pair in the same cycle it pops the
// current one.
//
// Ports:
//   clk        clock
//   reset      synchronous active-high reset (pointers and occupancy)
//   push       write wr_data at the tail
//   pop        retire the head entry
//   wr_data    entry to write
//   head_data  entry at the head
//   next_data  entry directly behind the head
//   count      occupancy, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module egress_pair_fifo #(
    parameter int WIDTH = 576,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         head_data,
    output logic [WIDTH-1:0]         next_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_ZERO = (AW + 1)'(0);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW-1:0]    rd_succ_s;
    logic [AW:0]      count_r;

    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign rd_succ_s = rd_ptr_r + PTR_ONE;

    assign head_data = mem_r[rd_ptr_r];
    assign next_data = mem_r[rd_succ_s];
    assign count     = count_r;
    assign full      = (count_r == CNT_FULL);
    assign empty     = (count_r == CNT_ZERO);

    // Payload storage; not reset, contents are only read behind valid pointers.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_r <= rd_succ_s;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/quote_egress_serializer.sv
// Quote egress serializer.
//
// Captures each buy/sell quote pair from the pipeline into a small FIFO and
// streams it out as REG_WIDTH-bit words: NUM_REGS buy words followed by
// NUM_REGS sell words. The upstream cannot be stalled, so a pair arriving
// into a full FIFO is dropped whole and counted.
//
// Ports:
//   i_clk, i_reset     clock, synchronous active-high reset
//   i_valid            one-cycle pulse, pair present on i_buy_msg/i_sell_msg
//   i_buy_msg          buy registers, reg k at [k*REG_WIDTH +: REG_WIDTH]
//   i_sell_msg         sell registers, same packing
//   o_tdata/o_tvalid   stream word and valid (registered)
//   i_tready           downstream accept
//   o_tlast            last word of the current side
//   o_tside            0 buy word, 1 sell word
//   o_count            FIFO occupancy
//   o_overflow         one-cycle pulse after a dropped pair
//   o_drop_count       saturating count of dropped pairs
module quote_egress_serializer #(
    parameter int REG_WIDTH      = 32,
    parameter int NUM_REGS       = hft_egress_pkg::NUM_REGS,
    parameter int DEPTH          = 4,
    parameter int DROP_CNT_WIDTH = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_valid,
    input  logic [NUM_REGS*REG_WIDTH-1:0] i_buy_msg,
    input  logic [NUM_REGS*REG_WIDTH-1:0] i_sell_msg,
    output logic [REG_WIDTH-1:0]          o_tdata,
    output logic                          o_tvalid,
    input  logic                          i_tready,
    output logic                          o_tlast,
    output logic                          o_tside,
    output logic [$clog2(DEPTH):0]        o_count,
    output logic                          o_overflow,
    output logic [DROP_CNT_WIDTH-1:0]     o_drop_count
);

    import hft_egress_pkg::egress_state_t;
    import hft_egress_pkg::egress_side_t;
    import hft_egress_pkg::IDLE;
    import hft_egress_pkg::SEND_BUY;
    import hft_egress_pkg::SEND_SELL;
    import hft_egress_pkg::SIDE_BUY;
    import hft_egress_pkg::SIDE_SELL;

    localparam int MSG_W   = NUM_REGS * REG_WIDTH;
    localparam int ENTRY_W = 2 * MSG_W;
    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int IDX_W   = $clog2(NUM_REGS + 1);

    localparam logic [IDX_W-1:0]          IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0]          IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(NUM_REGS - 1);
    localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_ONE = DROP_CNT_WIDTH'(1);
    localparam logic [DROP_CNT_WIDTH-1:0] DROP_MAX = {DROP_CNT_WIDTH{1'b1}};

    egress_state_t    state_r;
    egress_state_t    state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [IDX_W-1:0] idx_inc_s;

    logic                 tvalid_nxt_s;
    logic [REG_WIDTH-1:0] tdata_nxt_s;
    logic                 tlast_nxt_s;
    logic                 tside_nxt_s;

    logic handshake_s;
    logic last_word_s;
    logic pop_s;
    logic push_s;
    logic drop_s;
    logic more_after_pop_s;

    logic [ENTRY_W-1:0] fifo_wr_data_s;
    logic [ENTRY_W-1:0] fifo_head_s;
    logic [ENTRY_W-1:0] fifo_next_s;
    logic [ENTRY_W-1:0] follow_entry_s;
    logic [CNT_W-1:0]   fifo_count_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;

    // Entry layout: buy registers in the low half, sell registers above.
    function automatic logic [REG_WIDTH-1:0] pick_word(
        input logic [ENTRY_W-1:0] entry,
        input egress_side_t       side,
        input logic [IDX_W-1:0]   idx
    );
        int slot;
        slot = int'(idx);
        if (side == SIDE_SELL) begin
            slot = slot + NUM_REGS;
        end else begin
            slot = slot + 0;
        end
        return entry[slot*REG_WIDTH +: REG_WIDTH];
    endfunction

    assign fifo_wr_data_s = {i_sell_msg, i_buy_msg};

    assign handshake_s = o_tvalid && i_tready;
    assign last_word_s = (idx_r == IDX_LAST);
    assign idx_inc_s   = idx_r + IDX_ONE;

    // The head retires on the accepted last sell word.
    assign pop_s  = handshake_s && last_word_s && (state_r == SEND_SELL);
    // A full FIFO can still take a pair when the head leaves in the same cycle.
    assign push_s = i_valid && (!fifo_full_s || pop_s);
    assign drop_s = i_valid && !push_s;

    // After a pop the FIFO stays non-empty if more than one entry was held or
    // a new pair lands in the same cycle.
    assign more_after_pop_s = (fifo_count_s > CNT_ONE) || push_s;

    // With a single entry left, the pair that follows the head is the one being
    // pushed right now and is not in storage yet, so take it from the input.
    assign follow_entry_s = (fifo_count_s == CNT_ONE) ? fifo_wr_data_s : fifo_next_s;

    assign o_count = fifo_count_s;

    egress_pair_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_pair_fifo (
        .clk       (i_clk),
        .reset     (i_reset),
        .push      (push_s),
        .pop       (pop_s),
        .wr_data   (fifo_wr_data_s),
        .head_data (fifo_head_s),
        .next_data (fifo_next_s),
        .count     (fifo_count_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Next state, word index and next values of the registered stream outputs.
    always_comb begin
        state_nxt_s  = state_r;
        idx_nxt_s    = idx_r;
        tvalid_nxt_s = o_tvalid;
        tdata_nxt_s  = o_tdata;
        tlast_nxt_s  = o_tlast;
        tside_nxt_s  = o_tside;

        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) begin
                    state_nxt_s  = SEND_BUY;
                    idx_nxt_s    = IDX_ZERO;
                    tvalid_nxt_s = 1'b1;
                    tside_nxt_s  = SIDE_BUY;
                    tdata_nxt_s  = pick_word(fifo_head_s, SIDE_BUY, IDX_ZERO);
                    tlast_nxt_s  = (IDX_ZERO == IDX_LAST);
                end else begin
                    tvalid_nxt_s = 1'b0;
                    tlast_nxt_s  = 1'b0;
                end
            end

            SEND_BUY: begin
                if (handshake_s) begin
                    if (last_word_s) begin
                        state_nxt_s = SEND_SELL;
                        idx_nxt_s   = IDX_ZERO;
                        tside_nxt_s = SIDE_SELL;
                        tdata_nxt_s = pick_word(fifo_head_s, SIDE_SELL, IDX_ZERO);
                        tlast_nxt_s = (IDX_ZERO == IDX_LAST);
                    end else begin
                        idx_nxt_s   = idx_inc_s;
                        tdata_nxt_s = pick_word(fifo_head_s, SIDE_BUY, idx_inc_s);
                        tlast_nxt_s = (idx_inc_s == IDX_LAST);
                    end
                end else begin
                    // Stalled: every stream output holds its value.
                    state_nxt_s = SEND_BUY;
                end
            end

            SEND_SELL: begin
                if (handshake_s) begin
                    if (last_word_s) begin
                        idx_nxt_s = IDX_ZERO;
                        if (more_after_pop_s) begin
                            state_nxt_s = SEND_BUY;
                            tside_nxt_s = SIDE_BUY;
                            tdata_nxt_s = pick_word(follow_entry_s, SIDE_BUY, IDX_ZERO);
                            tlast_nxt_s = (IDX_ZERO == IDX_LAST);
                        end else begin
                            state_nxt_s  = IDLE;
                            tvalid_nxt_s = 1'b0;
                            tlast_nxt_s  = 1'b0;
                            tside_nxt_s  = SIDE_BUY;
                        end
                    end else begin
                        idx_nxt_s   = idx_inc_s;
                        tdata_nxt_s = pick_word(fifo_head_s, SIDE_SELL, idx_inc_s);
                        tlast_nxt_s = (idx_inc_s == IDX_LAST);
                    end
                end else begin
                    state_nxt_s = SEND_SELL;
                end
            end

            default: begin
                state_nxt_s  = IDLE;
                idx_nxt_s    = IDX_ZERO;
                tvalid_nxt_s = 1'b0;
                tlast_nxt_s  = 1'b0;
                tside_nxt_s  = SIDE_BUY;
            end
        endcase
    end

    // FSM state, word index and registered stream outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r  <= IDLE;
            idx_r    <= IDX_ZERO;
            o_tvalid <= 1'b0;
            o_tdata  <= {REG_WIDTH{1'b0}};
            o_tlast  <= 1'b0;
            o_tside  <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            idx_r    <= idx_nxt_s;
            o_tvalid <= tvalid_nxt_s;
            o_tdata  <= tdata_nxt_s;
            o_tlast  <= tlast_nxt_s;
            o_tside  <= tside_nxt_s;
        end
    end

    // Drop reporting: pulse plus saturating counter.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_overflow   <= 1'b0;
            o_drop_count <= {DROP_CNT_WIDTH{1'b0}};
        end else begin
            o_overflow <= drop_s;
            if (drop_s && (o_drop_count != DROP_MAX)) begin
                o_drop_count <= o_drop_count + DROP_ONE;
            end else begin
                o_drop_count <= o_drop_count;
            end
        end
    end

endmodule
